// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage and its register file.
package writeback_stage_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned PSR_W     = 3;

  // Result select encoding for W_Control
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_sel_e;

  localparam logic [PSR_W-1:0] PSR_N = 3'b100;
  localparam logic [PSR_W-1:0] PSR_Z = 3'b010;
  localparam logic [PSR_W-1:0] PSR_P = 3'b001;

  // NZP classification of a written value
  function automatic logic [PSR_W-1:0] psr_of(input logic [DATA_W-1:0] v);
    logic [PSR_W-1:0] r;
    r = PSR_P;
    if (v[DATA_W-1]) begin
      r = PSR_N;
    end else if (v == '0) begin
      r = PSR_Z;
    end
    return r;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback bus: result candidates and register indices in, flags and read data out.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic                enable_writeback;
  wb_sel_e             W_Control;
  logic [DATA_W-1:0]   aluout;
  logic [DATA_W-1:0]   memout;
  logic [DATA_W-1:0]   pcout;
  logic [DATA_W-1:0]   npc;
  logic [ADDR_W-1:0]   dr;
  logic [ADDR_W-1:0]   sr1;
  logic [ADDR_W-1:0]   sr2;
  logic                writeback_en_out;
  logic [PSR_W-1:0]    psr;
  logic [DATA_W-1:0]   VSR1;
  logic [DATA_W-1:0]   VSR2;

  modport master (
    output enable_writeback, W_Control, aluout, memout, pcout, npc, dr, sr1, sr2,
    input  writeback_en_out, psr, VSR1, VSR2
  );

  modport slave (
    input  enable_writeback, W_Control, aluout, memout, pcout, npc, dr, sr1, sr2,
    output writeback_en_out, psr, VSR1, VSR2
  );

endinterface

// File: rtl/writeback_regfile.sv
// 8x16 register file: one write port, two registered read ports with write-through.
module writeback_regfile
  import writeback_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] rf [REG_COUNT];

  // Storage: async clear, single write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        rf[i] <= '0;
      end
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  // Read ports registered every cycle; a same-cycle write to the read index is forwarded
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata1 <= (we && (raddr1 == waddr)) ? wdata : rf[raddr1];
      rdata2 <= (we && (raddr2 == waddr)) ? wdata : rf[raddr2];
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result, writes the register file, tracks NZP flags.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  writeback_stage_if.slave bus
);

  logic [DATA_W-1:0] dr_in;
  logic [PSR_W-1:0]  psr_q;
  logic              wben_q;

  // Result mux
  always_comb begin
    dr_in = bus.aluout;
    unique case (bus.W_Control)
      WB_ALU:  dr_in = bus.aluout;
      WB_MEM:  dr_in = bus.memout;
      WB_PC:   dr_in = bus.pcout;
      WB_NPC:  dr_in = bus.npc;
      default: dr_in = bus.aluout;
    endcase
  end

  // Flags follow each committed write; enable echo delayed one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psr_q  <= '0;
      wben_q <= 1'b0;
    end else begin
      wben_q <= bus.enable_writeback;
      if (bus.enable_writeback) begin
        psr_q <= psr_of(dr_in);
      end
    end
  end

  assign bus.psr              = psr_q;
  assign bus.writeback_en_out = wben_q;

  writeback_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (bus.enable_writeback),
    .waddr  (bus.dr),
    .wdata  (dr_in),
    .raddr1 (bus.sr1),
    .raddr2 (bus.sr2),
    .rdata1 (bus.VSR1),
    .rdata2 (bus.VSR2)
  );

endmodule
